// File: rtl/controlador_conversion_bcd.sv
// Serial binary-to-BCD converter using the double-dabble (shift-and-add-3) algorithm.
// One bit is processed per clock; the four BCD digits are registered and update only on completion.
module controlador_conversion_bcd #(
  parameter int unsigned ANCHO = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Inicio,
  input  logic [ANCHO-1:0] N_Binario,
  output logic             Ocupado,
  output logic             Listo,
  output logic [3:0]       Millares,
  output logic [3:0]       Centenas,
  output logic [3:0]       Decenas,
  output logic [3:0]       Unidades
);

  localparam int unsigned CntW = $clog2(ANCHO + 1);

  typedef enum logic {
    Reposo,
    Convertir
  } estado_e;

  estado_e          estado_q, estado_d;
  logic [ANCHO-1:0] shift_q, shift_d;
  logic [15:0]      scratch_q, scratch_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ocupado_q, ocupado_d;
  logic             listo_q, listo_d;
  logic [15:0]      bcd_q, bcd_d;

  logic [15:0]      corregido;
  logic [15:0]      desplazado;

  // All four digits are corrected in parallel before the shift.
  always_comb begin
    corregido = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        corregido[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign desplazado = {corregido[14:0], shift_q[ANCHO-1]};

  always_comb begin
    estado_d  = estado_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    ocupado_d = ocupado_q;
    listo_d   = 1'b0;
    bcd_d     = bcd_q;

    case (estado_q)
      Reposo: begin
        if (Inicio) begin
          shift_d   = N_Binario;
          scratch_d = '0;
          cnt_d     = CntW'(ANCHO);
          ocupado_d = 1'b1;
          estado_d  = Convertir;
        end
      end
      Convertir: begin
        scratch_d = desplazado;
        shift_d   = shift_q << 1;
        cnt_d     = cnt_q - CntW'(1);
        // Last step: publish the freshly shifted scratch directly.
        if (cnt_q == CntW'(1)) begin
          bcd_d     = desplazado;
          listo_d   = 1'b1;
          ocupado_d = 1'b0;
          estado_d  = Reposo;
        end
      end
      default: begin
        estado_d  = Reposo;
        ocupado_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q  <= Reposo;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
      bcd_q     <= '0;
    end else begin
      estado_q  <= estado_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ocupado_q <= ocupado_d;
      listo_q   <= listo_d;
      bcd_q     <= bcd_d;
    end
  end

  assign Ocupado  = ocupado_q;
  assign Listo    = listo_q;
  assign Millares = bcd_q[15:12];
  assign Centenas = bcd_q[11:8];
  assign Decenas  = bcd_q[7:4];
  assign Unidades = bcd_q[3:0];

endmodule

// File: tb/tb_controlador_conversion_bcd.sv
// Bench for controlador_conversion_bcd: a cycle-timestamp reference model checked every cycle,
// plus directed scenarios with literal expectations and an exhaustive 0..1023 sweep.
module tb_controlador_conversion_bcd;

  localparam int unsigned ANCHO = 10;

  logic             clk;
  logic             reset;
  logic             Inicio;
  logic [ANCHO-1:0] N_Binario;
  logic             Ocupado;
  logic             Listo;
  logic [3:0]       Millares;
  logic [3:0]       Centenas;
  logic [3:0]       Decenas;
  logic [3:0]       Unidades;

  int checks = 0;
  int errors = 0;
  int tb_cyc = 0;

  controlador_conversion_bcd #(
    .ANCHO(ANCHO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Inicio   (Inicio),
    .N_Binario(N_Binario),
    .Ocupado  (Ocupado),
    .Listo    (Listo),
    .Millares (Millares),
    .Centenas (Centenas),
    .Decenas  (Decenas),
    .Unidades (Unidades)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request at cycle c finishes exactly ANCHO cycles later.
  logic        m_busy = 1'b0;
  logic        m_listo = 1'b0;
  int          m_cyc = 0;
  int          m_done = 0;
  int          m_val = 0;
  logic [15:0] m_bcd = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy  <= 1'b0;
      m_listo <= 1'b0;
      m_bcd   <= '0;
      m_cyc   <= 0;
    end else begin
      m_cyc   <= m_cyc + 1;
      m_listo <= 1'b0;
      if (m_busy) begin
        if (m_cyc == m_done) begin
          m_busy  <= 1'b0;
          m_listo <= 1'b1;
          m_bcd   <= to_bcd(m_val);
        end
      end else if (Inicio) begin
        m_val  <= int'(N_Binario);
        m_done <= m_cyc + ANCHO;
        m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_ocupado", int'(Ocupado), int'(m_busy));
    chk("model_listo", int'(Listo), int'(m_listo));
    chk("model_millares", int'(Millares), int'(m_bcd[15:12]));
    chk("model_centenas", int'(Centenas), int'(m_bcd[11:8]));
    chk("model_decenas", int'(Decenas), int'(m_bcd[7:4]));
    chk("model_unidades", int'(Unidades), int'(m_bcd[3:0]));
  end

  function automatic int dut_bcd();
    return int'({Millares, Centenas, Decenas, Unidades});
  endfunction

  task automatic wait_listo(output int busy, output bit got, output int at_cyc);
    busy   = 0;
    got    = 1'b0;
    at_cyc = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (Ocupado) busy++;
      if (Listo) begin
        got    = 1'b1;
        at_cyc = tb_cyc;
      end
    end
  endtask

  task automatic conv(input int v, input int exp, input string tag, output int busy);
    bit got;
    int at;
    @(posedge clk);
    #2;
    Inicio    = 1'b1;
    N_Binario = ANCHO'(v);
    @(posedge clk);
    #2;
    Inicio = 1'b0;
    wait_listo(busy, got, at);
    chk({tag, "_listo_seen"}, int'(got), 1);
    chk({tag, "_digits"}, dut_bcd(), exp);
  endtask

  initial begin
    int busy;
    int at1;
    int at2;
    int lcount;
    bit got;

    reset     = 1'b1;
    Inicio    = 1'b0;
    N_Binario = '0;
    #1 reset  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ocupado", int'(Ocupado), 0);
    chk("rst_listo", int'(Listo), 0);
    chk("rst_digits", dut_bcd(), 0);
    @(posedge clk);
    #2 reset = 1'b1;

    // 1011: ten busy cycles, then digits 1,0,1,1
    conv(1011, 'h1011, "v1011", busy);
    chk("v1011_busy_cycles", busy, 10);

    conv(1023, 'h1023, "v1023", busy);
    conv(0, 'h0000, "v0", busy);

    // Inicio held high: 6 then 17, Listo pulses 11 cycles apart
    @(posedge clk);
    #2;
    Inicio    = 1'b1;
    N_Binario = ANCHO'(6);
    @(posedge clk);
    #2 N_Binario = ANCHO'(17);
    wait_listo(busy, got, at1);
    chk("hold_first_seen", int'(got), 1);
    chk("hold_first_digits", dut_bcd(), 'h0006);
    wait_listo(busy, got, at2);
    Inicio = 1'b0;
    chk("hold_second_seen", int'(got), 1);
    chk("hold_second_digits", dut_bcd(), 'h0017);
    chk("hold_listo_spacing", at2 - at1, 11);

    // Request and data change while busy must be ignored
    @(posedge clk);
    #2;
    Inicio    = 1'b1;
    N_Binario = ANCHO'(321);
    @(posedge clk);
    #2 Inicio = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    Inicio    = 1'b1;
    N_Binario = ANCHO'(999);
    @(posedge clk);
    #2 Inicio = 1'b0;
    @(negedge clk);
    chk("busy_digits_held", dut_bcd(), 'h0017);
    chk("busy_ocupado", int'(Ocupado), 1);
    wait_listo(busy, got, at1);
    chk("busy_listo_seen", int'(got), 1);
    chk("busy_result", dut_bcd(), 'h0321);

    // Reset mid-conversion of 500, then restart on the first edge after release
    @(posedge clk);
    #2;
    Inicio    = 1'b1;
    N_Binario = ANCHO'(500);
    @(posedge clk);
    #2 Inicio = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_ocupado", int'(Ocupado), 0);
    chk("abort_listo", int'(Listo), 0);
    chk("abort_digits", dut_bcd(), 0);
    repeat (2) @(posedge clk);
    #2;
    reset     = 1'b1;
    Inicio    = 1'b1;
    N_Binario = ANCHO'(500);
    @(posedge clk);
    #2 Inicio = 1'b0;
    lcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) chk("restart_ocupado", int'(Ocupado), 1);
      if (Listo) lcount++;
    end
    chk("abort_no_listo", lcount, 0);
    wait_listo(busy, got, at1);
    chk("restart_listo_seen", int'(got), 1);
    chk("restart_digits", dut_bcd(), 'h0500);

    // Exhaustive sweep against decimal arithmetic
    for (int v = 0; v < (1 << ANCHO); v++) begin
      conv(v, int'(to_bcd(v)), "sweep", busy);
      chk("sweep_millares_range", int'(Millares > 4'd9), 0);
      chk("sweep_centenas_range", int'(Centenas > 4'd9), 0);
      chk("sweep_decenas_range", int'(Decenas > 4'd9), 0);
      chk("sweep_unidades_range", int'(Unidades > 4'd9), 0);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
